jtag_tap_param: RTL and testbench
=================================

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4, instruction register width (legal range 2 to 8).
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0001, device ID; bit 0 SHALL be 1.
REQ-003 Parameter N_USER, default 2, number of external user data registers (legal range 1 to 4).
REQ-004 Port: TCLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: TRST  input  1  synchronous, active-high reset.
REQ-006 Port: TMS  input  1  TAP mode select.
REQ-007 Port: TDI  input  1  serial data in.
REQ-008 Port: TDO  output  1  serial data out; 0 when tdo_en is 0.
REQ-009 Port: tdo_en  output  1  high only in Shift-DR or Shift-IR.
REQ-010 Port: ext_tdo  input  N_USER+1  serial outputs of the external chains; bit 0 is the BSR, bits 1..N_USER are user registers.
REQ-011 Port: ext_sel  output  N_USER+1  one-hot select of the external chain addressed by the current instruction; all-zero otherwise.
REQ-012 Port: capture_dr, shift_dr, update_dr  output  1 each  high while the TAP is in the corresponding state (Capture-DR, Shift-DR, Update-DR).
REQ-013 Port: extest_mode  output  1  high while the current instruction is EXTEST (drives BSR mode).
REQ-014 Port: tap_state  output  4  current state encoding, for debug.

Function
REQ-015 The TAP FSM SHALL implement the 16 IEEE 1149.1 states and their TMS-driven transitions exactly, with encodings:
- TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8
- SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauseIR=13, Ex2IR=14, UpdIR=15
REQ-016 Five consecutive clocks with TMS=1 SHALL reach TLR from any state.
REQ-017 Instruction decode SHALL be:
- EXTEST = 0 and SAMPLE/PRELOAD = 2 both select ext bit 0.
- IDCODE = 1 selects the internal 32-bit ID register.
- USERk = 2+k, for k=1..N_USER, selects ext bit k.
- All-ones selects BYPASS.
- Any unlisted code SHALL behave as BYPASS.
REQ-018 CapIR SHALL load the IR shift register with {0..0,01}, i.e. value 1.
REQ-019 In ShIR, each clock SHALL shift the IR shift register right, TDI entering the MSB.
REQ-020 TDO in ShIR SHALL be the shift-register LSB, combinational from the current state.
REQ-021 UpdIR SHALL copy the shift register into the active instruction; the active instruction SHALL change at no other time except reset.
REQ-022 CapDR SHALL load the bypass bit with 0 and, under IDCODE, the ID register with IDCODE_VAL.
REQ-023 In ShDR, the selected internal register SHALL shift right with TDI into its MSB; TDO SHALL be its LSB.
REQ-024 For external chains, TDO SHALL equal ext_tdo[sel] in ShDR.
REQ-025 Pause and Exit states SHALL hold all shift-register contents unchanged.
REQ-026 ext_sel, capture_dr, shift_dr and update_dr SHALL be decoded from the registered state and instruction only (no TMS combinational path).
REQ-027 Latency: the TDI bit sampled on edge n SHALL appear at TDO after BYPASS length 1 (edge n+1), IDCODE length 32, or IR length IR_W.

Reset
REQ-028 TRST=1 at a rising edge SHALL set: state=TLR, active instruction=IDCODE (1), IR shift register=1, bypass=0, ID register=IDCODE_VAL.
REQ-029 Reset SHALL take priority over TMS, including mid-shift; the partially shifted data SHALL be discarded.
REQ-030 In TLR, the following SHALL be 0: tdo_en, TDO, capture_dr, shift_dr, update_dr and extest_mode.
REQ-031 In TLR, ext_sel SHALL be all-zero.

Verification
REQ-032 Reset then TMS sequence 0,1,0,0 then 32 shift clocks SHALL read out TDO LSB-first = 32'h1000_0001; tdo_en high exactly during those 32 clocks.
REQ-033 Load IR=4'hF, then shift DR with TDI pattern 1,0,1,1 SHALL give TDO = 0 (captured bypass), then 1,0,1, one clock delayed.
REQ-034 Load IR=0 SHALL give extest_mode=1 and ext_sel=3'b001.
REQ-035 Load IR=4 (USER2) SHALL give ext_sel=3'b100, with TDO following ext_tdo[2] in ShDR.
REQ-036 Assert TRST during the 10th ShDR clock SHALL give, at the next edge, state=0, instruction=1 and tdo_en=0.
REQ-037 From each of the 16 states, 5 clocks of TMS=1 SHALL give state=0; an IR shift SHALL read captured value 4'b0001 on TDO.

Source files
------------

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller with an IR, BYPASS and IDCODE registers, plus
// one-hot routing to an external boundary-scan chain and N_USER user chains.
module jtag_tap_param #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          N_USER     = 2
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              tdo_en,
  input  logic [N_USER:0]   ext_tdo,
  output logic [N_USER:0]   ext_sel,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  output logic              extest_mode,
  output logic [3:0]        tap_state
);

  localparam logic [3:0] TLR     = 4'd0;
  localparam logic [3:0] RTI     = 4'd1;
  localparam logic [3:0] SELDR   = 4'd2;
  localparam logic [3:0] CAPDR   = 4'd3;
  localparam logic [3:0] SHDR    = 4'd4;
  localparam logic [3:0] EX1DR   = 4'd5;
  localparam logic [3:0] PAUSEDR = 4'd6;
  localparam logic [3:0] EX2DR   = 4'd7;
  localparam logic [3:0] UPDDR   = 4'd8;
  localparam logic [3:0] SELIR   = 4'd9;
  localparam logic [3:0] CAPIR   = 4'd10;
  localparam logic [3:0] SHIR    = 4'd11;
  localparam logic [3:0] EX1IR   = 4'd12;
  localparam logic [3:0] PAUSEIR = 4'd13;
  localparam logic [3:0] EX2IR   = 4'd14;
  localparam logic [3:0] UPDIR   = 4'd15;

  localparam logic [IR_W-1:0] IR_EXTEST = '0;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(2);
  localparam logic [IR_W-1:0] IR_BYPASS = '1;

  logic [3:0]      state_reg, state_next;
  logic [IR_W-1:0] ir_reg, ir_next;
  logic [IR_W-1:0] ir_shift_reg, ir_shift_next;
  logic            bypass_reg, bypass_next;
  logic [31:0]     id_reg, id_next;
  logic [N_USER:0] ext_dec;
  logic            is_bypass_code;
  logic            sel_idcode;
  logic            sel_ext;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TLR:     state_next = TMS ? TLR   : RTI;
      RTI:     state_next = TMS ? SELDR : RTI;
      SELDR:   state_next = TMS ? SELIR : CAPDR;
      CAPDR:   state_next = TMS ? EX1DR : SHDR;
      SHDR:    state_next = TMS ? EX1DR : SHDR;
      EX1DR:   state_next = TMS ? UPDDR : PAUSEDR;
      PAUSEDR: state_next = TMS ? EX2DR : PAUSEDR;
      EX2DR:   state_next = TMS ? UPDDR : SHDR;
      UPDDR:   state_next = TMS ? SELDR : RTI;
      SELIR:   state_next = TMS ? TLR   : CAPIR;
      CAPIR:   state_next = TMS ? EX1IR : SHIR;
      SHIR:    state_next = TMS ? EX1IR : SHIR;
      EX1IR:   state_next = TMS ? UPDIR : PAUSEIR;
      PAUSEIR: state_next = TMS ? EX2IR : PAUSEIR;
      EX2IR:   state_next = TMS ? UPDIR : SHIR;
      UPDIR:   state_next = TMS ? SELDR : RTI;
      default: state_next = TLR;
    endcase
  end

  // All-ones always wins, so a user code that aliases it (small IR_W) stays BYPASS.
  assign is_bypass_code = (ir_reg == IR_BYPASS);
  assign sel_idcode     = (ir_reg == IR_IDCODE);
  assign ext_dec[0]     = (ir_reg == IR_EXTEST) || (ir_reg == IR_SAMPLE);

  genvar gi;
  generate
    for (gi = 1; gi <= N_USER; gi++) begin : g_user_dec
      if ((2 + gi) < (1 << IR_W) - 1) begin : g_fits
        assign ext_dec[gi] = !is_bypass_code && (ir_reg == IR_W'(2 + gi));
      end else begin : g_alias
        assign ext_dec[gi] = 1'b0;
      end
    end
  endgenerate

  assign sel_ext     = |ext_dec;
  assign ext_sel     = (state_reg != TLR) ? ext_dec : '0;
  assign extest_mode = (state_reg != TLR) && (ir_reg == IR_EXTEST);
  assign capture_dr  = (state_reg == CAPDR);
  assign shift_dr    = (state_reg == SHDR);
  assign update_dr   = (state_reg == UPDDR);
  assign tdo_en      = (state_reg == SHDR) || (state_reg == SHIR);
  assign tap_state   = state_reg;

  always_comb begin
    TDO = 1'b0;
    if (state_reg == SHIR) begin
      TDO = ir_shift_reg[0];
    end else if (state_reg == SHDR) begin
      if (sel_ext)         TDO = |(ext_dec & ext_tdo);
      else if (sel_idcode) TDO = id_reg[0];
      else                 TDO = bypass_reg;
    end
  end

  // Pause/Exit states fall through to the hold defaults.
  always_comb begin
    ir_next       = ir_reg;
    ir_shift_next = ir_shift_reg;
    bypass_next   = bypass_reg;
    id_next       = id_reg;
    case (state_reg)
      CAPIR: ir_shift_next = IR_W'(1);
      SHIR:  ir_shift_next = {TDI, ir_shift_reg[IR_W-1:1]};
      UPDIR: ir_next = ir_shift_reg;
      CAPDR: begin
        bypass_next = 1'b0;
        if (sel_idcode) id_next = IDCODE_VAL;
      end
      SHDR: begin
        if (sel_idcode)    id_next = {TDI, id_reg[31:1]};
        else if (!sel_ext) bypass_next = TDI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCLK) begin
    if (TRST) begin
      state_reg    <= TLR;
      ir_reg       <= IR_IDCODE;
      ir_shift_reg <= IR_W'(1);
      bypass_reg   <= 1'b0;
      id_reg       <= IDCODE_VAL;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      ir_shift_reg <= ir_shift_next;
      bypass_reg   <= bypass_next;
      id_reg       <= id_next;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: stimulus queues expected TDO bits and
// status values; a negedge monitor pops and compares them.
module tb_jtag_tap_param;

  logic       TCLK = 1'b0;
  logic       TRST, TMS, TDI;
  logic       TDO, tdo_en;
  logic [2:0] ext_tdo, ext_sel;
  logic       capture_dr, shift_dr, update_dr, extest_mode;
  logic [3:0] tap_state;

  localparam int S_STATE = 0, S_TDOEN = 1, S_TDO = 2, S_EXTSEL = 3,
                 S_EXTEST = 4, S_CAP = 5, S_SHIFT = 6, S_UPD = 7;

  int n_cmp = 0;
  int n_mis = 0;
  int tdo_idx = 0;

  string       chk_name_q[$];
  int          chk_sel_q[$];
  logic [31:0] chk_exp_q[$];
  bit          tdo_q[$];

  always #5 TCLK = ~TCLK;

  jtag_tap_param dut (
    .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .ext_tdo(ext_tdo), .ext_sel(ext_sel), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .extest_mode(extest_mode),
    .tap_state(tap_state)
  );

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_STATE:  return {28'd0, tap_state};
      S_TDOEN:  return {31'd0, tdo_en};
      S_TDO:    return {31'd0, TDO};
      S_EXTSEL: return {29'd0, ext_sel};
      S_EXTEST: return {31'd0, extest_mode};
      S_CAP:    return {31'd0, capture_dr};
      S_SHIFT:  return {31'd0, shift_dr};
      S_UPD:    return {31'd0, update_dr};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: status checks drain each negedge; a TDO bit is consumed whenever tdo_en is high.
  always @(negedge TCLK) begin : monitor
    string       nm;
    int          sl;
    logic [31:0] ex, act;
    bit          eb;
    while (chk_name_q.size() > 0) begin
      nm = chk_name_q.pop_front();
      sl = chk_sel_q.pop_front();
      ex = chk_exp_q.pop_front();
      act = probe(sl);
      n_cmp++;
      if (act !== ex) begin
        n_mis++;
        $display("FAIL %s: got %0h expected %0h", nm, act, ex);
      end else begin
        $display("check %s = %0h ok", nm, act);
      end
    end
    n_cmp++;
    if (tdo_en === 1'b1) begin
      if (tdo_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_tdo_en: got tdo_en=1 expected 0 (state %0d)", tap_state);
      end else begin
        eb = tdo_q.pop_front();
        if (TDO !== eb) begin
          n_mis++;
          $display("FAIL tdo[%0d]: got %b expected %b (state %0d)", tdo_idx, TDO, eb, tap_state);
        end
        tdo_idx++;
      end
    end else if (TDO !== 1'b0) begin
      n_mis++;
      $display("FAIL tdo_idle: got %b expected 0 (tdo_en=%b)", TDO, tdo_en);
    end
  end

  task automatic step(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [31:0] v);
    chk_name_q.push_back(name);
    chk_sel_q.push_back(sel);
    chk_exp_q.push_back(v);
  endtask

  task automatic do_reset(input bit tms);
    TRST = 1'b1;
    step(tms, 1'b0);
    TRST = 1'b0;
  endtask

  // From TLR or RTI: scan in v (LSB first), expecting the captured 0001 out, end in RTI.
  task automatic load_ir(input logic [3:0] v);
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      tdo_q.push_back(i == 0);
      step(i == 3, v[i]);
    end
    step(1, 0);
    step(0, 0);
  endtask

  task automatic goto_shdr();
    step(1, 0);
    step(0, 0);
    expect_sig("capture_dr", S_CAP, 1);
    step(0, 0);
    expect_sig("shift_dr", S_SHIFT, 1);
  endtask

  task automatic leave_dr();
    expect_sig("state_ex1dr", S_STATE, 5);
    step(1, 0);
    expect_sig("update_dr", S_UPD, 1);
    step(0, 0);
    expect_sig("state_rti", S_STATE, 1);
  endtask

  task automatic read_idcode();
    logic [31:0] idv;
    idv = 32'h1000_0001;
    goto_shdr();
    for (int i = 0; i < 32; i++) begin
      tdo_q.push_back(idv[i]);
      step(i == 31, i[0]);
    end
    leave_dr();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          plen [16];
    logic [6:0]  pbits[16];
    logic [3:0]  bp_tdi, bp_exp;
    logic [2:0]  ev [4];
    logic [3:0]  eexp;

    plen  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    pbits = '{7'b0000000, 7'b0000000, 7'b0000010, 7'b0000010,
              7'b0000010, 7'b0001010, 7'b0001010, 7'b0101010,
              7'b0011010, 7'b0000110, 7'b0000110, 7'b0000110,
              7'b0010110, 7'b0010110, 7'b1010110, 7'b0110110};

    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; ext_tdo = 3'b000;
    step(1, 0);
    step(1, 0);
    TRST = 1'b0;

    $display("txn reset_state");
    expect_sig("rst_state", S_STATE, 0);
    expect_sig("rst_tdo_en", S_TDOEN, 0);
    expect_sig("rst_tdo", S_TDO, 0);
    expect_sig("rst_capture", S_CAP, 0);
    expect_sig("rst_shift", S_SHIFT, 0);
    expect_sig("rst_update", S_UPD, 0);
    expect_sig("rst_extest", S_EXTEST, 0);
    expect_sig("rst_ext_sel", S_EXTSEL, 0);
    step(0, 0);
    expect_sig("state_rti0", S_STATE, 1);

    $display("txn idcode_read");
    read_idcode();

    $display("txn bypass");
    load_ir(4'hF);
    expect_sig("bypass_ext_sel", S_EXTSEL, 0);
    expect_sig("bypass_extest", S_EXTEST, 0);
    goto_shdr();
    bp_tdi = 4'b1101;  // sent 1,0,1,1 LSB-first
    bp_exp = 4'b1010;  // seen 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      tdo_q.push_back(bp_exp[i]);
      step(i == 3, bp_tdi[i]);
    end
    leave_dr();

    $display("txn extest");
    load_ir(4'h0);
    expect_sig("extest_mode", S_EXTEST, 1);
    expect_sig("extest_ext_sel", S_EXTSEL, 3'b001);
    goto_shdr();
    ev[0] = 3'b001; ev[1] = 3'b110; ev[2] = 3'b011;
    eexp = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      ext_tdo = ev[i];
      tdo_q.push_back(eexp[i]);
      step(i == 2, 1'b0);
    end
    ext_tdo = 3'b000;
    leave_dr();

    $display("txn sample_preload");
    load_ir(4'h2);
    expect_sig("sample_extest", S_EXTEST, 0);
    expect_sig("sample_ext_sel", S_EXTSEL, 3'b001);
    step(0, 0);

    $display("txn user1");
    load_ir(4'h3);
    expect_sig("user1_ext_sel", S_EXTSEL, 3'b010);
    step(0, 0);

    $display("txn user2");
    load_ir(4'h4);
    expect_sig("user2_ext_sel", S_EXTSEL, 3'b100);
    goto_shdr();
    ev[0] = 3'b100; ev[1] = 3'b011; ev[2] = 3'b111; ev[3] = 3'b000;
    eexp = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      ext_tdo = ev[i];
      tdo_q.push_back(eexp[i]);
      step(i == 3, 1'b0);
    end
    ext_tdo = 3'b000;
    leave_dr();

    $display("txn unlisted_code");
    load_ir(4'h7);
    expect_sig("unlisted_ext_sel", S_EXTSEL, 0);
    goto_shdr();
    tdo_q.push_back(1'b0);
    step(0, 1);
    tdo_q.push_back(1'b1);
    step(1, 1);
    leave_dr();

    $display("txn reset_mid_shift");
    load_ir(4'h4);
    goto_shdr();
    ext_tdo = 3'b100;
    for (int i = 0; i < 9; i++) begin
      tdo_q.push_back(1'b1);
      step(0, 1);
    end
    tdo_q.push_back(1'b1);
    TRST = 1'b1;
    step(0, 1);
    TRST = 1'b0;
    ext_tdo = 3'b000;
    expect_sig("midrst_state", S_STATE, 0);
    expect_sig("midrst_tdo_en", S_TDOEN, 0);
    expect_sig("midrst_ext_sel", S_EXTSEL, 0);
    step(0, 0);
    expect_sig("midrst_instr_ext_sel", S_EXTSEL, 0);
    read_idcode();

    $display("txn fsm_sweep");
    for (int k = 0; k < 16; k++) begin
      do_reset(1'b1);
      for (int j = 0; j < plen[k]; j++) step(pbits[k][j], 1'b0);
      if (k == 4 || k == 11) tdo_q.push_back(1'b1);
      expect_sig($sformatf("sweep_reach_%0d", k), S_STATE, k);
      for (int j = 0; j < 5; j++) step(1, 0);
      expect_sig($sformatf("sweep_tlr_from_%0d", k), S_STATE, 0);
    end

    $display("txn ir_capture_after_sweep");
    load_ir(4'hF);
    step(0, 0);
    step(0, 0);

    if (tdo_q.size() != 0 || chk_name_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL leftover_expectations: got %0d tdo and %0d status unconsumed expected 0",
               tdo_q.size(), chk_name_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
